// File: rtl/irq_ctrl.sv
// -----------------------------------------------------------------------------
// irq_ctrl
//
// Interrupt controller sitting in front of coprocessor-0. Six asynchronous
// interrupt pins are synchronized, their rising edges are latched as pending,
// and exactly one pending, unmasked line at a time is presented to the
// coprocessor as a clean registered one-hot level. The granted line is then
// tracked through acknowledge and end-of-interrupt.
//
// Parameters
//   NUM_IRQ      number of interrupt lines (6; other values unsupported)
//   SYNC_STAGES  synchronizer depth per line (2..3)
//
// Ports
//   clk       in   system clock, all logic on posedge
//   rst       in   synchronous active-high reset
//   irq_in    in   [5:0] raw asynchronous interrupt pins, active-high
//   mask      in   [5:0] per-line enable (Status[15:10]), 1 = enabled
//   ie        in   global interrupt enable (Status[0])
//   exl       in   exception level, 1 = handler active (blocks new grants)
//   ack       in   one-cycle pulse: granted interrupt taken
//   eoi       in   one-cycle end-of-interrupt strobe
//   eoi_id    in   [2:0] line being retired by eoi
//   irq_out   out  [5:0] registered one-hot grant, 0 when nothing granted
//   irq_id    out  [2:0] index of the granted / in-service line
//   busy      out  high while in REQ or SERVICE
//   pending   out  [5:0] latched pending bits
//   missed    out  [7:0] saturating count of edges lost on pending lines
//
// Handshake: irq_out is a level held for as long as the request stands. A
// request is consumed only by ack sampled high while in REQ; it can be
// withdrawn (pending bit kept) if its mask bit or ie drops first. ack outside
// REQ and eoi outside SERVICE (or with a non-matching eoi_id) have no effect.
//
// Configuration macro
//   IRQ_CTRL_RR_EN  defined: round-robin arbitration with a last-served
//                   pointer (reset 5, updated on ack, search starts at
//                   pointer+1 wrapping 5->0).
//                   undefined: fixed priority, index 0 highest.
// -----------------------------------------------------------------------------
module irq_ctrl #(
  parameter int NUM_IRQ     = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [NUM_IRQ-1:0] mask,
  input  logic               ie,
  input  logic               exl,
  input  logic               ack,
  input  logic               eoi,
  input  logic [2:0]         eoi_id,
  output logic [NUM_IRQ-1:0] irq_out,
  output logic [2:0]         irq_id,
  output logic               busy,
  output logic [NUM_IRQ-1:0] pending,
  output logic [7:0]         missed
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t state_q, state_n;

  // ---------------------------------------------------------------------------
  // Synchronizer, history flop and registered edge detect.
  // The edge is registered so that a pin sampled high at edge N becomes
  // pending after edge N+SYNC_STAGES+1.
  // ---------------------------------------------------------------------------
  logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [NUM_IRQ-1:0] hist_q;
  logic [NUM_IRQ-1:0] edge_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      hist_q <= '0;
      edge_q <= '0;
    end else begin
      sync_q[0] <= irq_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      hist_q <= sync_q[SYNC_STAGES-1];
      edge_q <= sync_q[SYNC_STAGES-1] & ~hist_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Eligibility and arbitration
  // ---------------------------------------------------------------------------
  logic [NUM_IRQ-1:0] eligible;
  logic               win_found;
  logic [2:0]         win_id;

  assign eligible = pending & mask & {NUM_IRQ{ie & ~exl}};

`ifdef IRQ_CTRL_RR_EN
  logic [2:0] ptr_q;

  // Search order starts just after the last-served line and wraps.
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_id    = 3'd0;
    idx       = 0;
    for (int k = 1; k <= NUM_IRQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_IRQ;
      if (!win_found && eligible[idx]) begin
        win_found = 1'b1;
        win_id    = 3'(idx);
      end
    end
  end
`else
  // Fixed priority: scanning downward leaves the lowest eligible index.
  always_comb begin
    win_found = 1'b0;
    win_id    = 3'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        win_found = 1'b1;
        win_id    = 3'(i);
      end
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // FSM next-state logic
  // ---------------------------------------------------------------------------
  logic [NUM_IRQ-1:0] id_onehot;
  logic [NUM_IRQ-1:0] clr;
  logic [2:0]         id_n;
  logic               take;

  assign id_onehot = NUM_IRQ'(1) << irq_id;

  always_comb begin
    state_n = state_q;
    id_n    = irq_id;
    clr     = '0;
    take    = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_n = REQ;
          id_n    = win_id;
        end
      end
      REQ: begin
        // ack has priority over a simultaneous withdraw; exl does not withdraw.
        if (ack) begin
          state_n = SERVICE;
          clr     = id_onehot;
          take    = 1'b1;
        end else if (((id_onehot & mask) == '0) || !ie) begin
          state_n = IDLE;
        end
      end
      SERVICE: begin
        if (eoi && (eoi_id == irq_id)) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pending / missed bookkeeping.
  // A new edge overrides the clear from ack on the same line, and such an
  // edge is not counted as missed since the bit was being consumed.
  // ---------------------------------------------------------------------------
  logic [NUM_IRQ-1:0] pending_n;
  logic [NUM_IRQ-1:0] miss_vec;
  logic [8:0]         missed_sum;
  logic [7:0]         missed_n;

  always_comb begin
    pending_n  = (pending & ~clr) | edge_q;
    miss_vec   = edge_q & pending & ~clr;
    missed_sum = 9'(missed) + 9'($countones(miss_vec));
    missed_n   = (missed_sum > 9'd255) ? 8'hFF : missed_sum[7:0];
  end

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      irq_id  <= 3'd0;
      irq_out <= '0;
      busy    <= 1'b0;
      pending <= '0;
      missed  <= 8'd0;
    end else begin
      state_q <= state_n;
      irq_id  <= id_n;
      irq_out <= (state_n == REQ) ? (NUM_IRQ'(1) << id_n) : '0;
      busy    <= (state_n != IDLE);
      pending <= pending_n;
      missed  <= missed_n;
    end
  end

`ifdef IRQ_CTRL_RR_EN
  always_ff @(posedge clk) begin
    if (rst)       ptr_q <= 3'd5;
    else if (take) ptr_q <= irq_id;
  end
`else
  // take only drives the round-robin pointer; nothing to update here.
  logic unused_take;
  assign unused_take = take;
`endif

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl. Stimulus pushes expected grants into exp_q;
// a monitor pops and compares each time irq_out goes from 0 to nonzero.
module tb_irq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] irq_in;
  logic [5:0] mask;
  logic       ie;
  logic       exl;
  logic       ack;
  logic       eoi;
  logic [2:0] eoi_id;
  logic [5:0] irq_out;
  logic [2:0] irq_id;
  logic       busy;
  logic [5:0] pending;
  logic [7:0] missed;

  int n_tests = 0;
  int n_fail  = 0;

  // {irq_id, irq_out} of each expected grant, in order
  logic [8:0] exp_q[$];

  irq_ctrl #(.NUM_IRQ(6), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .mask(mask), .ie(ie), .exl(exl),
    .ack(ack), .eoi(eoi), .eoi_id(eoi_id), .irq_out(irq_out), .irq_id(irq_id),
    .busy(busy), .pending(pending), .missed(missed)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_grant(input logic [2:0] id);
    logic [5:0] oh;
    oh = 6'd1 << id;
    exp_q.push_back({id, oh});
  endtask

  task automatic do_ack();
    ack = 1'b1; tick(1); ack = 1'b0;
  endtask

  task automatic do_eoi(input logic [2:0] id);
    eoi = 1'b1; eoi_id = id; tick(1); eoi = 1'b0; eoi_id = 3'd0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [5:0] prev_out;
    logic [8:0] e;
    prev_out = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("onehot", 16'($countones(irq_out) <= 1), 16'd1);
        if (irq_out != 6'd0 && prev_out == 6'd0) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL grant_unexpected: got irq_out=%b irq_id=%0d expected no grant", irq_out, irq_id);
          end else begin
            e = exp_q.pop_front();
            chk("grant_out", 16'(irq_out), 16'(e[5:0]));
            chk("grant_id", 16'(irq_id), 16'(e[8:6]));
          end
        end
      end
      prev_out = irq_out;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0] first_id, second_id;
    rst = 1'b1; irq_in = '0; mask = 6'h3F; ie = 1'b1; exl = 1'b0;
    ack = 1'b0; eoi = 1'b0; eoi_id = 3'd0;
    tick(3);
    chk("rst_irq_out", 16'(irq_out), 16'h0);
    chk("rst_irq_id", 16'(irq_id), 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_pending", 16'(pending), 16'h0);
    chk("rst_missed", 16'(missed), 16'h0);
    rst = 1'b0;
    tick(1);

    // ---- single line 3, latency check ----
    push_grant(3'd3);
    irq_in = 6'b001000; tick(1); irq_in = '0;
    tick(2);
    chk("t1_pend_early", 16'(pending), 16'h00);
    tick(1);
    chk("t1_pend_set", 16'(pending), 16'h08);
    chk("t1_no_grant_yet", 16'(irq_out), 16'h00);
    tick(1);
    chk("t1_grant_out", 16'(irq_out), 16'h08);
    chk("t1_grant_id", 16'(irq_id), 16'd3);
    chk("t1_busy_req", 16'(busy), 16'd1);
    do_ack();
    chk("t1_ack_out", 16'(irq_out), 16'h00);
    chk("t1_ack_pend", 16'(pending), 16'h00);
    chk("t1_busy_srv", 16'(busy), 16'd1);
    do_eoi(3'd3);
    chk("t1_eoi_busy", 16'(busy), 16'd0);

    // ---- priority: lines 5 and 1 together ----
`ifdef IRQ_CTRL_RR_EN
    first_id = 3'd5; second_id = 3'd1;
`else
    first_id = 3'd1; second_id = 3'd5;
`endif
    push_grant(first_id);
    push_grant(second_id);
    irq_in = 6'b100010; tick(1); irq_in = '0;
    tick(4);
    chk("t2_first", 16'(irq_id), 16'(first_id));
    do_ack();
    do_eoi(first_id);
    chk("t2_gap", 16'(irq_out), 16'h00);
    tick(1);
    chk("t2_second", 16'(irq_id), 16'(second_id));
    do_ack();
    do_eoi(second_id);

    // ---- withdraw on mask drop ----
    push_grant(3'd2);
    irq_in = 6'b000100; tick(1); irq_in = '0;
    tick(4);
    chk("t3_grant", 16'(irq_out), 16'h04);
    mask = 6'h3B; tick(1);
    chk("t3_wd_out", 16'(irq_out), 16'h00);
    chk("t3_wd_busy", 16'(busy), 16'd0);
    chk("t3_wd_pend", 16'(pending), 16'h04);
    push_grant(3'd2);
    mask = 6'h3F; tick(1);
    chk("t3_regrant", 16'(irq_out), 16'h04);
    do_ack();
    do_eoi(3'd2);

    // ---- missed edges and ack collision on line 4 ----
    push_grant(3'd4);
    irq_in = 6'b010000; tick(1); irq_in = '0;
    tick(4);
    chk("t4_grant", 16'(irq_out), 16'h10);
    irq_in = 6'b010000; tick(1); irq_in = '0; tick(1);
    irq_in = 6'b010000; tick(1); irq_in = '0; tick(4);
    chk("t4_missed2", 16'(missed), 16'd2);
    chk("t4_pend", 16'(pending), 16'h10);
    chk("t4_still_req", 16'(irq_out), 16'h10);
    // edge reaches the pending logic on the same edge that samples ack
    irq_in = 6'b010000; tick(1); irq_in = '0; tick(2);
    do_ack();
    chk("t4_coll_pend", 16'(pending), 16'h10);
    chk("t4_coll_missed", 16'(missed), 16'd2);
    chk("t4_coll_out", 16'(irq_out), 16'h00);
    push_grant(3'd4);
    do_eoi(3'd4);
    tick(1);
    chk("t4_regrant", 16'(irq_out), 16'h10);
    do_ack();
    do_eoi(3'd4);

    // ---- gating by exl and ie ----
    exl = 1'b1;
    irq_in = 6'b000010; tick(1); irq_in = '0;
    tick(5);
    chk("t5_exl_out", 16'(irq_out), 16'h00);
    chk("t5_exl_busy", 16'(busy), 16'd0);
    chk("t5_exl_pend", 16'(pending), 16'h02);
    push_grant(3'd1);
    exl = 1'b0; tick(1);
    chk("t5_exl_release", 16'(irq_out), 16'h02);
    exl = 1'b1; tick(1);
    chk("t5_exl_keep", 16'(irq_out), 16'h02);
    do_ack();
    exl = 1'b0;
    do_eoi(3'd1);
    ie = 1'b0;
    irq_in = 6'b000001; tick(1); irq_in = '0;
    tick(5);
    chk("t5_ie_out", 16'(irq_out), 16'h00);
    chk("t5_ie_pend", 16'(pending), 16'h01);
    push_grant(3'd0);
    ie = 1'b1; tick(1);
    chk("t5_ie_release", 16'(irq_out), 16'h01);
    do_ack();

    // ---- reset while line 0 is in service ----
    do_eoi(3'd2);
    chk("t6_wrong_eoi", 16'(busy), 16'd1);
    rst = 1'b1; tick(1);
    chk("t6_rst_out", 16'(irq_out), 16'h00);
    chk("t6_rst_busy", 16'(busy), 16'd0);
    chk("t6_rst_pend", 16'(pending), 16'h00);
    chk("t6_rst_missed", 16'(missed), 16'd0);
    chk("t6_rst_id", 16'(irq_id), 16'd0);
    rst = 1'b0; tick(2);
    chk("t6_idle", 16'(busy), 16'd0);

    // ---- missed counter saturation (ie=0 keeps line 3 pending) ----
    ie = 1'b0;
    irq_in = 6'b001000; tick(1); irq_in = '0; tick(4);
    for (int i = 0; i < 254; i++) begin
      irq_in = 6'b001000; tick(1); irq_in = '0; tick(1);
    end
    tick(4);
    chk("t7_missed254", 16'(missed), 16'd254);
    for (int i = 0; i < 6; i++) begin
      irq_in = 6'b001000; tick(1); irq_in = '0; tick(1);
    end
    tick(4);
    chk("t7_missed_sat", 16'(missed), 16'd255);
    chk("t7_no_grant", 16'(irq_out), 16'h00);
    rst = 1'b1; tick(1); rst = 1'b0; ie = 1'b1;

    tick(3);
    chk("exp_q_drained", 16'(exp_q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
